// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Takes a length-prefixed byte stream and assembles little-endian words.
// Writes each word through the ROM write port, one strobe per word.
// Keeps the CPU (PC counter enable) held off until the whole image is in.

module imem_loader #(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter int                     DEPTH_WORDS   = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                     clk,
    input  logic                     rst,       // asynchronous, active-low
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0]    wd,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cpu_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e                   state_q, state_d;
    logic [15:0]              len_q, len_d;        // word count N from the header
    logic [15:0]              idx_q, idx_d;        // index of the word being written
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [23:0]              asm_q, asm_d;        // first three bytes of the current word
    logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;

    logic        xfer;
    logic [15:0] len_full;
    logic        len_bad;
    logic        last_word;

    // A byte moves only when both sides agree in the same cycle.
    assign xfer      = rx_valid && rx_ready;

    // Header is complete once the high byte arrives; validate it on the fly.
    assign len_full  = {rx_data, len_q[7:0]};
    assign len_bad   = (len_full == 16'd0) ||
                       ({16'd0, len_full} > 32'(DEPTH_WORDS));

    // The word written this cycle is the last one of the image.
    assign last_word = (idx_q + 16'd1) == len_q;

    assign wa     = wa_q;
    assign wd     = wd_q;
    assign cpu_en = done;

    // Next-state logic and Moore-style outputs of the load sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        rx_ready   = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LEN0;
                    idx_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                end
            end

            S_LEN0: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN1;
                end
            end

            S_LEN1: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    len_d[15:8] = rx_data;
                    state_d     = len_bad ? S_ERR : S_DATA;
                end
            end

            S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        2'd3: begin
                            // Present address and data together with the strobe
                            // in the WRITE cycle that follows.
                            wd_d    = {rx_data, asm_q};
                            wa_d    = BASE_ADDR + ADDRESS_WIDTH'({idx_q, 2'b00});
                            state_d = S_WRITE;
                        end
                        default: ;
                    endcase
                end
            end

            S_WRITE: begin
                we      = 1'b1;
                busy    = 1'b1;
                idx_d   = idx_q + 16'd1;
                state_d = last_word ? S_DONE : S_DATA;
            end

            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d    = S_LEN0;
                    idx_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                end
            end

            S_ERR: begin
                error = 1'b1;
                if (start) begin
                    state_d    = S_LEN0;
                    idx_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any partial load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            idx_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            wa_q       <= BASE_ADDR;
            wd_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the pre-edge state, independent of statement order.
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

endmodule
